// File: rtl/rr_arb_2to1.sv
// rr_arb_2to1 -- two-requester round-robin arbiter feeding a one-entry
// registered output buffer.
//
// Ports:
//   clk_i               clock; all state changes on its rising edge
//   rst_ni              asynchronous active-low reset
//   a_valid_i/a_data_i  requester A transfer and payload
//   a_ready_o           requester A accepted this cycle
//   b_valid_i/b_data_i  requester B transfer and payload
//   b_ready_o           requester B accepted this cycle
//   y_valid_o/y_data_o  output buffer holds a transfer / its payload
//   y_ready_i           consumer accepts the output transfer
//   sel_o               source of the held transfer (0 = A, 1 = B)
module rr_arb_2to1 #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              a_valid_i,
  input  logic [DATA_W-1:0] a_data_i,
  output logic              a_ready_o,
  input  logic              b_valid_i,
  input  logic [DATA_W-1:0] b_data_i,
  output logic              b_ready_o,
  output logic              y_valid_o,
  output logic [DATA_W-1:0] y_data_o,
  input  logic              y_ready_i,
  output logic              sel_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              sel_q,   sel_d;
  logic              prio_q,  prio_d;   // 0 = A wins contention, 1 = B wins

  logic accept_en;
  logic grant_a;
  logic grant_b;

  // Buffer can take a new transfer when empty, or when it drains this cycle.
  // Gated by rst_ni so no requester is readied while reset is held.
  always_comb begin
    accept_en = rst_ni & ((state_q == EMPTY) | y_ready_i);
    grant_a   = accept_en & a_valid_i & (~b_valid_i | ~prio_q);
    grant_b   = accept_en & b_valid_i & (~a_valid_i |  prio_q);
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    prio_d  = prio_q;
    if (grant_a | grant_b) begin
      state_d = FULL;
      data_d  = grant_b ? b_data_i : a_data_i;
      sel_d   = grant_b;
      prio_d  = ~grant_b;               // favour the requester not served
    end else if ((state_q == FULL) && y_ready_i) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      prio_q  <= prio_d;
    end
  end

  assign a_ready_o = grant_a;
  assign b_ready_o = grant_b;
  assign y_valid_o = (state_q == FULL);
  assign y_data_o  = data_q;
  assign sel_o     = sel_q;

endmodule

// File: tb/tb_rr_arb_2to1.sv
// Testbench for rr_arb_2to1: directed scenarios followed by a randomized run,
// all checked against a transaction-level model of the arbiter.
module tb_rr_arb_2to1;

  localparam int unsigned DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              a_valid, b_valid, y_ready;
  logic [DATA_W-1:0] a_data, b_data;
  logic              a_ready, b_ready, y_valid, sel;
  logic [DATA_W-1:0] y_data;

  int checks   = 0;
  int failures = 0;

  // Model: the buffer is a queue of at most one {source, payload} entry;
  // 'next_winner' names who wins the next contended grant.
  typedef struct packed { logic src; logic [DATA_W-1:0] data; } xfer_t;
  xfer_t m_buf[$];
  xfer_t m_last;            // last transfer loaded (what the output shows)
  int    next_winner;

  rr_arb_2to1 #(.DATA_W(DATA_W)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .a_valid_i(a_valid),
    .a_data_i (a_data),
    .a_ready_o(a_ready),
    .b_valid_i(b_valid),
    .b_data_i (b_data),
    .b_ready_o(b_ready),
    .y_valid_o(y_valid),
    .y_data_o (y_data),
    .y_ready_i(y_ready),
    .sel_o    (sel)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_buf.delete();
    m_last      = '0;
    next_winner = 0;
  endtask

  // One clock cycle: drive inputs, check readies against the model, clock,
  // then check the registered outputs. Call between edges (not near posedge).
  task automatic cycle(input logic va, input logic [DATA_W-1:0] da,
                       input logic vb, input logic [DATA_W-1:0] db,
                       input logic yr, input string tag);
    int    winner;
    xfer_t x;
    a_valid = va; a_data = da; b_valid = vb; b_data = db; y_ready = yr;
    #1;
    winner = -1;
    if (m_buf.size() == 0 || yr) begin
      if (va && vb)  winner = next_winner;
      else if (va)   winner = 0;
      else if (vb)   winner = 1;
    end
    chk({tag, ".a_ready"}, a_ready, winner == 0);
    chk({tag, ".b_ready"}, b_ready, winner == 1);
    chk({tag, ".ready_excl"}, a_ready & b_ready, 1'b0);
    @(posedge clk);
    #1;
    if (yr && m_buf.size() != 0) void'(m_buf.pop_front());
    if (winner >= 0) begin
      x.src  = (winner == 1);
      x.data = (winner == 1) ? db : da;
      m_buf.push_back(x);
      m_last = x;
      next_winner = 1 - winner;
    end
    chk({tag, ".y_valid"}, y_valid, m_buf.size() != 0);
    chk({tag, ".y_data"},  y_data,  m_last.data);
    chk({tag, ".sel"},     sel,     m_last.src);
  endtask

  logic [DATA_W-1:0] exp_seq [4];
  logic [DATA_W-1:0] held;

  initial begin
    a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h55; b_data = 8'h66; y_ready = 1'b1;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // Reset state, readies forced low even with both requesters valid
    chk("rst.y_valid", y_valid, 1'b0);
    chk("rst.y_data",  y_data,  8'h00);
    chk("rst.sel",     sel,     1'b0);
    chk("rst.a_ready", a_ready, 1'b0);
    chk("rst.b_ready", b_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester A
    cycle(1'b1, 8'h11, 1'b0, 8'h00, 1'b1, "single");
    chk("single.data_const", y_data, 8'h11);
    chk("single.sel_const",  sel,    1'b0);
    // Drain without refill
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, "drain1");
    chk("drain1.valid_const", y_valid, 1'b0);

    // Contention from reset: A, B, A, B
    @(negedge clk); rst_n = 1'b0; model_reset();
    @(negedge clk); rst_n = 1'b1;
    exp_seq[0] = 8'h0A; exp_seq[1] = 8'h0B; exp_seq[2] = 8'h0A; exp_seq[3] = 8'h0B;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 8'h0A, 1'b1, 8'h0B, 1'b1, "contend");
      chk("contend.data_const", y_data, exp_seq[i]);
      chk("contend.sel_const",  sel,    logic'(i % 2));
    end

    // Backpressure: load 0x0A, hold 3 cycles with B pending, then release
    cycle(1'b1, 8'h0A, 1'b1, 8'h0B, 1'b1, "bp_load");
    chk("bp_load.data_const", y_data, 8'h0A);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 8'h0B, 1'b0, "bp_hold");
      chk("bp_hold.data_const", y_data, 8'h0A);
      chk("bp_hold.valid_const", y_valid, 1'b1);
    end
    a_valid = 1'b0; b_valid = 1'b1; b_data = 8'h0B; y_ready = 1'b1;
    #1;
    chk("bp_release.b_ready_const", b_ready, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 8'h0B, 1'b1, "bp_release");
    chk("bp_release.data_const", y_data, 8'h0B);
    chk("bp_release.sel_const",  sel,    1'b1);

    // Drain, prio unchanged (A next), then load B alone: FULL with 0x0B, prio=0
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, "drain2");
    chk("drain2.valid_const", y_valid, 1'b0);
    cycle(1'b1, 8'h21, 1'b1, 8'h22, 1'b1, "prio_kept");
    chk("prio_kept.sel_const", sel, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 8'h0B, 1'b1, "load_b");
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, "hold_b");
    chk("hold_b.data_const", y_data, 8'h0B);

    // Reset mid-operation, asserted between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.y_valid", y_valid, 1'b0);
    chk("midrst.y_data",  y_data,  8'h00);
    chk("midrst.sel",     sel,     1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 8'h31, 1'b1, 8'h32, 1'b1, "post_rst");
    chk("post_rst.sel_const", sel, 1'b0);

    // Randomized run, including the output-stability invariant under stall
    for (int i = 0; i < 400; i++) begin
      held = y_data;
      if (y_valid && !y_ready) chk("inv.stable_pre", y_data, held);
      cycle(logic'($urandom_range(0, 1)), 8'($urandom),
            logic'($urandom_range(0, 1)), 8'($urandom),
            logic'($urandom_range(0, 3) != 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Output must not change while a stalled transfer is held
  logic              prev_stall;
  logic [DATA_W-1:0] prev_data;
  always @(posedge clk) begin
    if (rst_n && prev_stall) begin
      checks++;
      assert (y_valid === 1'b1 && y_data === prev_data) else begin
        failures++;
        $error("FAIL stall_hold observed=%0h/%0b expected=%0h/1", y_data, y_valid, prev_data);
      end
    end
  end
  always @(negedge clk) begin
    prev_stall = rst_n && y_valid && !y_ready;
    prev_data  = y_data;
  end

endmodule
